// File: rtl/gmii_tx_arbiter_if.sv
// Bundle of the two frame-source handshakes and the shared GMII transmit outputs.
// master = frame-source side, slave = arbiter side.
interface gmii_tx_arbiter_if;
    logic       req0;
    logic       gnt0;
    logic       tx_en0;
    logic [7:0] txd0;
    logic       req1;
    logic       gnt1;
    logic       tx_en1;
    logic [7:0] txd1;
    logic       gmii_tx_en;
    logic [7:0] gmii_txd;
    logic       busy;
    logic       trunc;

    modport master (
        output req0, tx_en0, txd0, req1, tx_en1, txd1,
        input  gnt0, gnt1, gmii_tx_en, gmii_txd, busy, trunc
    );

    modport slave (
        input  req0, tx_en0, txd0, req1, tx_en1, txd1,
        output gnt0, gnt1, gmii_tx_en, gmii_txd, busy, trunc
    );
endinterface

// File: rtl/gmii_tx_arbiter.sv
// Two-source round-robin arbiter onto one GMII transmit path with IFG, grant timeout
// and over-length truncation. Optional statistics counters under `TX_ARB_STAT_EN.
module gmii_tx_arbiter #(
    parameter int IFG_CYCLES  = 12,
    parameter int GNT_TIMEOUT = 64,
    parameter int MAX_LEN     = 1526
) (
    input  logic               gmii_tx_clk,
    input  logic               rst,
    gmii_tx_arbiter_if.slave   bus
`ifdef TX_ARB_STAT_EN
    ,
    output logic [15:0]        frame_cnt0,
    output logic [15:0]        frame_cnt1,
    output logic [7:0]         trunc_cnt
`endif
);

    localparam logic [15:0] MAX_LEN_C = 16'(MAX_LEN);
    localparam logic [15:0] TO_LAST_C = 16'(GNT_TIMEOUT - 1);
    localparam logic [7:0]  IFG_C     = 8'(IFG_CYCLES);

    typedef enum logic [2:0] {
        IDLE,
        GRANT,
        SEND,
        DRAIN,
        IFG
    } state_e;

    state_e      state_q, state_d;
    logic        sel_q, sel_d;       // source currently owning the link
    logic        last_q, last_d;     // last-served source
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] to_q, to_d;
    logic [7:0]  ifg_q, ifg_d;
    logic        tx_en_q, tx_en_d;
    logic [7:0]  txd_q, txd_d;
    logic        trunc_q, trunc_d;

    logic        req_g;
    logic        en_g;
    logic [7:0]  txd_g;

    assign req_g = sel_q ? bus.req1   : bus.req0;
    assign en_g  = sel_q ? bus.tx_en1 : bus.tx_en0;
    assign txd_g = sel_q ? bus.txd1   : bus.txd0;

    // NOTE: every always_comb output is given a default first so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        to_d    = to_q;
        ifg_d   = ifg_q;
        tx_en_d = 1'b0;
        txd_d   = 8'h00;
        trunc_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.req0 || bus.req1) begin
                    state_d = GRANT;
                    sel_d   = (bus.req0 && bus.req1) ? ~last_q : bus.req1;
                    last_d  = sel_d;
                    cnt_d   = 16'd0;
                    to_d    = 16'd0;
                end
            end
            GRANT: begin
                if (en_g) begin
                    state_d = SEND;
                    tx_en_d = 1'b1;
                    txd_d   = txd_g;
                    cnt_d   = cnt_q + 16'd1;
                end else if (!req_g || to_q == TO_LAST_C) begin
                    state_d = IDLE;
                end else begin
                    to_d = to_q + 16'd1;
                end
            end
            SEND: begin
                if (!en_g) begin
                    state_d = IFG;
                    ifg_d   = IFG_C;
                end else if (cnt_q == MAX_LEN_C) begin
                    state_d = DRAIN;
                    trunc_d = 1'b1;
                end else begin
                    tx_en_d = 1'b1;
                    txd_d   = txd_g;
                    cnt_d   = cnt_q + 16'd1;
                end
            end
            DRAIN: begin
                if (!en_g) begin
                    state_d = IFG;
                    ifg_d   = IFG_C;
                end
            end
            IFG: begin
                if (ifg_q == 8'd1) begin
                    state_d = IDLE;
                end else begin
                    ifg_d = ifg_q - 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only; reset is synchronous.
    always_ff @(posedge gmii_tx_clk) begin
        if (rst) begin
            state_q <= IDLE;
            sel_q   <= 1'b0;
            last_q  <= 1'b1;
            cnt_q   <= 16'd0;
            to_q    <= 16'd0;
            ifg_q   <= 8'd0;
            tx_en_q <= 1'b0;
            txd_q   <= 8'h00;
            trunc_q <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            to_q    <= to_d;
            ifg_q   <= ifg_d;
            tx_en_q <= tx_en_d;
            txd_q   <= txd_d;
            trunc_q <= trunc_d;
        end
    end

    logic owning;
    assign owning = (state_q == GRANT) || (state_q == SEND);

    assign bus.gnt0       = owning && !sel_q;
    assign bus.gnt1       = owning &&  sel_q;
    assign bus.gmii_tx_en = tx_en_q;
    assign bus.gmii_txd   = txd_q;
    assign bus.busy       = (state_q != IDLE);
    assign bus.trunc      = trunc_q;

`ifdef TX_ARB_STAT_EN
    logic [15:0] frame_cnt0_q;
    logic [15:0] frame_cnt1_q;
    logic [7:0]  trunc_cnt_q;
    logic        frame_done;

    // Only a normal SEND->IFG end counts as a completed frame.
    assign frame_done = (state_q == SEND) && (state_d == IFG);

    always_ff @(posedge gmii_tx_clk) begin
        if (rst) begin
            frame_cnt0_q <= 16'd0;
            frame_cnt1_q <= 16'd0;
            trunc_cnt_q  <= 8'd0;
        end else begin
            if (frame_done && !sel_q) frame_cnt0_q <= frame_cnt0_q + 16'd1;
            if (frame_done &&  sel_q) frame_cnt1_q <= frame_cnt1_q + 16'd1;
            if (trunc_d && trunc_cnt_q != 8'hFF) trunc_cnt_q <= trunc_cnt_q + 8'd1;
        end
    end

    assign frame_cnt0 = frame_cnt0_q;
    assign frame_cnt1 = frame_cnt1_q;
    assign trunc_cnt  = trunc_cnt_q;
`endif

endmodule

// File: tb/tb_gmii_tx_arbiter.sv
// Directed bench for gmii_tx_arbiter (IFG 12, timeout 64, MAX_LEN 100).
// Observed word layout: {gnt0, gnt1, busy, trunc, gmii_tx_en, gmii_txd}.
module tb_gmii_tx_arbiter;

    localparam int IFG  = 12;
    localparam int TOUT = 64;
    localparam int MLEN = 100;

    logic gmii_tx_clk = 1'b0;
    logic rst         = 1'b1;

    int vectors     = 0;
    int miscompares = 0;

    gmii_tx_arbiter_if bus ();

`ifdef TX_ARB_STAT_EN
    logic [15:0] frame_cnt0;
    logic [15:0] frame_cnt1;
    logic [7:0]  trunc_cnt;
`endif

    gmii_tx_arbiter #(
        .IFG_CYCLES (IFG),
        .GNT_TIMEOUT(TOUT),
        .MAX_LEN    (MLEN)
    ) dut (
        .gmii_tx_clk(gmii_tx_clk),
        .rst        (rst),
        .bus        (bus)
`ifdef TX_ARB_STAT_EN
        ,
        .frame_cnt0 (frame_cnt0),
        .frame_cnt1 (frame_cnt1),
        .trunc_cnt  (trunc_cnt)
`endif
    );

    always #4 gmii_tx_clk = ~gmii_tx_clk;

    logic [12:0] obs;
    assign obs = {bus.gnt0, bus.gnt1, bus.busy, bus.trunc, bus.gmii_tx_en, bus.gmii_txd};

    // Outputs are read 1 ns after the edge; inputs changed there are sampled on the next edge.
    task automatic step();
        @(posedge gmii_tx_clk);
        #1;
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        bus.req0   = 1'b0;
        bus.tx_en0 = 1'b0;
        bus.txd0   = 8'h00;
        bus.req1   = 1'b0;
        bus.tx_en1 = 1'b0;
        bus.txd1   = 8'h00;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        vectors++;
        if (obs !== 13'h0000) begin
            miscompares++;
            $display("FAIL reset_state: got %h expected %h", obs, 13'h0000);
        end
    endtask

    task automatic test_single_frame();
        int n;
        do_reset();
        bus.req0 = 1'b1;
        step();
        vectors++;
        if (obs !== {5'b10100, 8'h00}) begin
            miscompares++;
            $display("FAIL single_gnt0: got %h expected %h", obs, {5'b10100, 8'h00});
        end
        for (int i = 0; i < 60; i++) begin
            bus.tx_en0 = 1'b1;
            bus.txd0   = 8'(i);
            step();
            vectors++;
            if (obs !== {5'b10101, 8'(i)}) begin
                miscompares++;
                $display("FAIL single_byte%0d: got %h expected %h", i, obs, {5'b10101, 8'(i)});
            end
        end
        bus.tx_en0 = 1'b0;
        bus.req0   = 1'b0;
        step();
        vectors++;
        if (obs !== {5'b00100, 8'h00}) begin
            miscompares++;
            $display("FAIL single_ifg_entry: got %h expected %h", obs, {5'b00100, 8'h00});
        end
        n = 0;
        while (bus.busy && n < 50) begin
            step();
            n++;
        end
        vectors++;
        if (n != IFG) begin
            miscompares++;
            $display("FAIL single_ifg_len: got %0d expected %0d", n, IFG);
        end
    endtask

    task automatic test_tie_round_robin();
        int n;
        int bad;
        do_reset();
        bus.req0 = 1'b1;
        bus.req1 = 1'b1;
        step();
        vectors++;
        if (obs !== {5'b10100, 8'h00}) begin
            miscompares++;
            $display("FAIL tie_first_gnt0: got %h expected %h", obs, {5'b10100, 8'h00});
        end
        // source 1 toggles garbage while not granted; it must not reach the PHY
        for (int i = 0; i < 10; i++) begin
            bus.tx_en0 = 1'b1;
            bus.txd0   = 8'(8'h10 + i);
            bus.tx_en1 = 1'b1;
            bus.txd1   = 8'hEE;
            step();
            vectors++;
            if (obs !== {5'b10101, 8'(8'h10 + i)}) begin
                miscompares++;
                $display("FAIL tie_src0_byte%0d: got %h expected %h", i, obs, {5'b10101, 8'(8'h10 + i)});
            end
        end
        bus.tx_en0 = 1'b0;
        bus.tx_en1 = 1'b0;
        step();
        n   = 1;
        bad = 0;
        while (!bus.gnt1 && n < 60) begin
            if (bus.gmii_tx_en || bus.gnt0) bad++;
            step();
            n++;
        end
        vectors++;
        if (n != IFG + 2 || bad != 0) begin
            miscompares++;
            $display("FAIL tie_gap_to_gnt1: got %0d cycles (%0d bad) expected %0d (0 bad)", n, bad, IFG + 2);
        end
        for (int i = 0; i < 5; i++) begin
            bus.tx_en1 = 1'b1;
            bus.txd1   = 8'(8'hA0 + i);
            step();
            vectors++;
            if (obs !== {5'b01101, 8'(8'hA0 + i)}) begin
                miscompares++;
                $display("FAIL tie_src1_byte%0d: got %h expected %h", i, obs, {5'b01101, 8'(8'hA0 + i)});
            end
        end
        bus.tx_en1 = 1'b0;
        step();
        n = 1;
        while (!bus.gnt0 && !bus.gnt1 && n < 60) begin
            step();
            n++;
        end
        vectors++;
        if (n != IFG + 2 || obs !== {5'b10100, 8'h00}) begin
            miscompares++;
            $display("FAIL tie_second_gnt0: got %h after %0d cycles expected %h after %0d", obs, n, {5'b10100, 8'h00}, IFG + 2);
        end
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        step();
        vectors++;
        if (obs !== 13'h0000) begin
            miscompares++;
            $display("FAIL tie_req_drop_idle: got %h expected %h", obs, 13'h0000);
        end
    endtask

    task automatic test_grant_timeout();
        int n;
        do_reset();
        bus.req1 = 1'b1;
        step();
        vectors++;
        if (obs !== {5'b01100, 8'h00}) begin
            miscompares++;
            $display("FAIL timeout_gnt1: got %h expected %h", obs, {5'b01100, 8'h00});
        end
        bus.req0 = 1'b1;
        n = 0;
        while (bus.gnt1 && n < 100) begin
            step();
            n++;
        end
        vectors++;
        if (n != TOUT || obs !== 13'h0000) begin
            miscompares++;
            $display("FAIL timeout_release: got %h after %0d cycles expected %h after %0d", obs, n, 13'h0000, TOUT);
        end
        bus.req1 = 1'b0;
        step();
        vectors++;
        if (obs !== {5'b10100, 8'h00}) begin
            miscompares++;
            $display("FAIL timeout_next_gnt0: got %h expected %h", obs, {5'b10100, 8'h00});
        end
        bus.req0 = 1'b0;
        step();
        vectors++;
        if (obs !== 13'h0000) begin
            miscompares++;
            $display("FAIL timeout_idle: got %h expected %h", obs, 13'h0000);
        end
    endtask

    task automatic test_truncation();
        int n;
        int tr;
        logic [12:0] exp;
        do_reset();
        bus.req0 = 1'b1;
        step();
        tr = 0;
        for (int i = 0; i < 150; i++) begin
            bus.tx_en0 = 1'b1;
            bus.txd0   = 8'(i);
            step();
            if (bus.trunc) tr++;
            if (i < MLEN) exp = {5'b10101, 8'(i)};
            else          exp = {2'b00, 1'b1, (i == MLEN), 1'b0, 8'h00};
            vectors++;
            if (obs !== exp) begin
                miscompares++;
                $display("FAIL trunc_byte%0d: got %h expected %h", i, obs, exp);
            end
        end
        bus.tx_en0 = 1'b0;
        bus.req0   = 1'b0;
        step();
        vectors++;
        if (obs !== {5'b00100, 8'h00}) begin
            miscompares++;
            $display("FAIL trunc_ifg_entry: got %h expected %h", obs, {5'b00100, 8'h00});
        end
        n = 0;
        while (bus.busy && n < 50) begin
            step();
            n++;
        end
        vectors++;
        if (n != IFG || tr != 1) begin
            miscompares++;
            $display("FAIL trunc_tail: got ifg %0d pulses %0d expected ifg %0d pulses 1", n, tr, IFG);
        end
    endtask

    task automatic test_reset_mid_frame();
        bus.req0 = 1'b1;
        step();
        for (int i = 0; i < 30; i++) begin
            bus.tx_en0 = 1'b1;
            bus.txd0   = 8'(i);
            step();
            vectors++;
            if (obs !== {5'b10101, 8'(i)}) begin
                miscompares++;
                $display("FAIL rstmid_byte%0d: got %h expected %h", i, obs, {5'b10101, 8'(i)});
            end
        end
        rst      = 1'b1;
        bus.txd0 = 8'd30;
        step();
        vectors++;
        if (obs !== 13'h0000) begin
            miscompares++;
            $display("FAIL rstmid_drop: got %h expected %h", obs, 13'h0000);
        end
        rst        = 1'b0;
        bus.tx_en0 = 1'b0;
        step();
        vectors++;
        if (obs !== {5'b10100, 8'h00}) begin
            miscompares++;
            $display("FAIL rstmid_regrant: got %h expected %h", obs, {5'b10100, 8'h00});
        end
        bus.req0 = 1'b0;
        step();
    endtask

`ifdef TX_ARB_STAT_EN
    task automatic run_frame(input bit src, input int len, output bit ok);
        int n;
        if (src) bus.req1 = 1'b1;
        else     bus.req0 = 1'b1;
        n = 0;
        while (!(src ? bus.gnt1 : bus.gnt0) && n < 100) begin
            step();
            n++;
        end
        ok = src ? bus.gnt1 : bus.gnt0;
        for (int i = 0; i < len; i++) begin
            if (src) begin bus.tx_en1 = 1'b1; bus.txd1 = 8'(i); end
            else     begin bus.tx_en0 = 1'b1; bus.txd0 = 8'(i); end
            step();
        end
        bus.tx_en0 = 1'b0;
        bus.tx_en1 = 1'b0;
        bus.req0   = 1'b0;
        bus.req1   = 1'b0;
        step();
        n = 0;
        while (bus.busy && n < 100) begin
            step();
            n++;
        end
        ok = ok && !bus.busy;
    endtask

    task automatic test_stats();
        bit ok;
        bit all_ok;
        do_reset();
        vectors++;
        if ({frame_cnt0, frame_cnt1, trunc_cnt} !== 40'h0) begin
            miscompares++;
            $display("FAIL stat_reset: got %h expected %h", {frame_cnt0, frame_cnt1, trunc_cnt}, 40'h0);
        end
        all_ok = 1'b1;
        run_frame(1'b0, 4, ok);   all_ok &= ok;
        run_frame(1'b1, 110, ok); all_ok &= ok;
        run_frame(1'b0, 6, ok);   all_ok &= ok;
        run_frame(1'b1, 8, ok);   all_ok &= ok;
        run_frame(1'b0, 5, ok);   all_ok &= ok;
        vectors++;
        if (!all_ok) begin
            miscompares++;
            $display("FAIL stat_frames_ran: got %0d expected 1", all_ok);
        end
        vectors++;
        if ({frame_cnt0, frame_cnt1, trunc_cnt} !== {16'd3, 16'd1, 8'd1}) begin
            miscompares++;
            $display("FAIL stat_counts: got %0d/%0d/%0d expected 3/1/1", frame_cnt0, frame_cnt1, trunc_cnt);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single_frame();
        test_tie_round_robin();
        test_grant_timeout();
        test_truncation();
        test_reset_mid_frame();
`ifdef TX_ARB_STAT_EN
        test_stats();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
